sa_read_arbiter: RTL and testbench

- Per-slave read-address arbiter that sits between the MST_AMT read dispatchers and one slave's AR port.
- Selects one pending AR request per transaction, using round-robin by default, and registers it onto the slave AR channel.
- Counts the slave's outstanding read bursts against a limit.
- Pushes the granted master index to the R-return path so read data can be routed back in order.

---
 rtl/sa_read_arbiter_pkg.sv | 20 ++
 rtl/sa_rr_picker.sv | 34 +++
 rtl/sa_read_arbiter.sv | 151 +++++++++++++++
 tb/tb_sa_read_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sa_read_arbiter_pkg.sv
// Shared types and field widths for the slave-side AR/AW arbiters and the dispatchers.
package sa_read_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sa_state_e;

  localparam int SA_TRANS_MST_ID_W    = 5;
  localparam int SA_TRANS_BURST_W     = 2;
  localparam int SA_TRANS_DATA_LEN_W  = 3;
  localparam int SA_TRANS_DATA_SIZE_W = 3;
  localparam int SA_ADDR_WIDTH        = 32;

  // One extra bit so the counter can hold the limit value itself.
  function automatic int outst_cnt_w(input int outstanding_amt);
    return $clog2(outstanding_amt) + 1;
  endfunction

endpackage

// File: rtl/sa_rr_picker.sv
// Combinational rotating-priority picker: the search starts at ptr and wraps.
module sa_rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N-1:0]     gnt_onehot
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    gnt_valid  = 1'b0;
    gnt_idx    = '0;
    gnt_onehot = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      cand_idx = IDX_W'(cand);
      if (!gnt_valid && req[cand_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
    if (gnt_valid) gnt_onehot = N'(1) << gnt_idx;
  end

endmodule

// File: rtl/sa_read_arbiter.sv
// Per-slave AR arbiter with outstanding-burst limiting and R-route index push.
// SA_AR_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
//
// state | meaning
// IDLE  | no AR pending; pick a winner when a request is present and the limit allows
// BUSY  | s_ARVALID_o asserted with the winner's fields held until s_ARREADY_i
module sa_read_arbiter
  import sa_read_arbiter_pkg::*;
#(
  parameter int MST_AMT           = 2,
  parameter int MST_ID_W          = $clog2(MST_AMT),
  parameter int OUTSTANDING_AMT   = 8,
  parameter int ADDR_WIDTH        = SA_ADDR_WIDTH,
  parameter int TRANS_MST_ID_W    = SA_TRANS_MST_ID_W,
  parameter int TRANS_BURST_W     = SA_TRANS_BURST_W,
  parameter int TRANS_DATA_LEN_W  = SA_TRANS_DATA_LEN_W,
  parameter int TRANS_DATA_SIZE_W = SA_TRANS_DATA_SIZE_W
) (
  input  logic                                  ACLK_i,
  input  logic                                  ARESETn_i,
  input  logic [TRANS_MST_ID_W*MST_AMT-1:0]     dsp_ARID_i,
  input  logic [ADDR_WIDTH*MST_AMT-1:0]         dsp_ARADDR_i,
  input  logic [TRANS_BURST_W*MST_AMT-1:0]      dsp_ARBURST_i,
  input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]   dsp_ARLEN_i,
  input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]  dsp_ARSIZE_i,
  input  logic [MST_AMT-1:0]                    dsp_ARVALID_i,
  output logic [MST_AMT-1:0]                    dsp_ARREADY_o,
  output logic [TRANS_MST_ID_W-1:0]             s_ARID_o,
  output logic [ADDR_WIDTH-1:0]                 s_ARADDR_o,
  output logic [TRANS_BURST_W-1:0]              s_ARBURST_o,
  output logic [TRANS_DATA_LEN_W-1:0]           s_ARLEN_o,
  output logic [TRANS_DATA_SIZE_W-1:0]          s_ARSIZE_o,
  output logic                                  s_ARVALID_o,
  input  logic                                  s_ARREADY_i,
  input  logic                                  s_RLAST_i,
  input  logic                                  s_RVALID_i,
  input  logic                                  s_RREADY_i,
  output logic [MST_ID_W-1:0]                   grant_mst_o,
  output logic                                  grant_push_o,
  output logic                                  outst_full_o
);

  localparam int CNT_W = outst_cnt_w(OUTSTANDING_AMT);

  logic [TRANS_MST_ID_W-1:0]    id_arr    [MST_AMT];
  logic [ADDR_WIDTH-1:0]        addr_arr  [MST_AMT];
  logic [TRANS_BURST_W-1:0]     burst_arr [MST_AMT];
  logic [TRANS_DATA_LEN_W-1:0]  len_arr   [MST_AMT];
  logic [TRANS_DATA_SIZE_W-1:0] size_arr  [MST_AMT];

  for (genvar m = 0; m < MST_AMT; m++) begin : g_unpack
    assign id_arr[m]    = dsp_ARID_i[m*TRANS_MST_ID_W +: TRANS_MST_ID_W];
    assign addr_arr[m]  = dsp_ARADDR_i[m*ADDR_WIDTH +: ADDR_WIDTH];
    assign burst_arr[m] = dsp_ARBURST_i[m*TRANS_BURST_W +: TRANS_BURST_W];
    assign len_arr[m]   = dsp_ARLEN_i[m*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
    assign size_arr[m]  = dsp_ARSIZE_i[m*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
  end

  sa_state_e          state;
  logic [CNT_W-1:0]   outst_cnt;
  logic [MST_ID_W-1:0] rr_ptr;
  logic [MST_ID_W-1:0] winner;
  logic               pick_valid;
  logic [MST_ID_W-1:0] pick_idx;
  logic [MST_AMT-1:0] pick_onehot;
  logic               grant;
  logic               ar_hs;
  logic               r_dec;

  sa_rr_picker #(
    .N     (MST_AMT),
    .IDX_W (MST_ID_W)
  ) u_picker (
    .req        (dsp_ARVALID_i),
    .ptr        (rr_ptr),
    .gnt_valid  (pick_valid),
    .gnt_idx    (pick_idx),
    .gnt_onehot (pick_onehot)
  );

  assign grant        = (state == IDLE) && pick_valid && !outst_full_o;
  assign ar_hs        = s_ARVALID_o && s_ARREADY_i;
  assign r_dec        = s_RVALID_i && s_RREADY_i && s_RLAST_i && (outst_cnt != '0);
  assign outst_full_o = (outst_cnt == CNT_W'(OUTSTANDING_AMT));
  assign grant_push_o = ar_hs;
  assign grant_mst_o  = winner;

`ifdef SA_AR_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge ACLK_i) begin
    if (!ARESETn_i) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (pick_idx == MST_ID_W'(MST_AMT - 1)) ? '0 : pick_idx + 1'b1;
    end
  end
`endif

  // Handshake and retirement in the same cycle cancel out.
  always_ff @(posedge ACLK_i) begin
    if (!ARESETn_i) begin
      outst_cnt <= '0;
    end else begin
      case ({ar_hs, r_dec})
        2'b10:   outst_cnt <= outst_cnt + 1'b1;
        2'b01:   outst_cnt <= outst_cnt - 1'b1;
        default: outst_cnt <= outst_cnt;
      endcase
    end
  end

  always_ff @(posedge ACLK_i) begin
    if (!ARESETn_i) begin
      state         <= IDLE;
      s_ARVALID_o   <= 1'b0;
      s_ARID_o      <= '0;
      s_ARADDR_o    <= '0;
      s_ARBURST_o   <= '0;
      s_ARLEN_o     <= '0;
      s_ARSIZE_o    <= '0;
      dsp_ARREADY_o <= '0;
      winner        <= '0;
    end else begin
      dsp_ARREADY_o <= '0;
      case (state)
        IDLE: begin
          if (grant) begin
            s_ARID_o      <= id_arr[pick_idx];
            s_ARADDR_o    <= addr_arr[pick_idx];
            s_ARBURST_o   <= burst_arr[pick_idx];
            s_ARLEN_o     <= len_arr[pick_idx];
            s_ARSIZE_o    <= size_arr[pick_idx];
            winner        <= pick_idx;
            dsp_ARREADY_o <= pick_onehot;
            s_ARVALID_o   <= 1'b1;
            state         <= BUSY;
          end
        end
        BUSY: begin
          if (s_ARREADY_i) begin
            s_ARVALID_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_read_arbiter.sv
// Directed self-checking bench for sa_read_arbiter (round-robin or SA_AR_FIXED_PRIO_EN build).
module tb_sa_read_arbiter;

  logic        ACLK_i = 1'b0;
  logic        ARESETn_i;
  logic [9:0]  dsp_ARID_i;
  logic [63:0] dsp_ARADDR_i;
  logic [3:0]  dsp_ARBURST_i;
  logic [5:0]  dsp_ARLEN_i;
  logic [5:0]  dsp_ARSIZE_i;
  logic [1:0]  dsp_ARVALID_i;
  logic [1:0]  dsp_ARREADY_o;
  logic [4:0]  s_ARID_o;
  logic [31:0] s_ARADDR_o;
  logic [1:0]  s_ARBURST_o;
  logic [2:0]  s_ARLEN_o;
  logic [2:0]  s_ARSIZE_o;
  logic        s_ARVALID_o;
  logic        s_ARREADY_i;
  logic        s_RLAST_i;
  logic        s_RVALID_i;
  logic        s_RREADY_i;
  logic [0:0]  grant_mst_o;
  logic        grant_push_o;
  logic        outst_full_o;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  int exp_ptr = 0;

  sa_read_arbiter dut (
    .ACLK_i        (ACLK_i),
    .ARESETn_i     (ARESETn_i),
    .dsp_ARID_i    (dsp_ARID_i),
    .dsp_ARADDR_i  (dsp_ARADDR_i),
    .dsp_ARBURST_i (dsp_ARBURST_i),
    .dsp_ARLEN_i   (dsp_ARLEN_i),
    .dsp_ARSIZE_i  (dsp_ARSIZE_i),
    .dsp_ARVALID_i (dsp_ARVALID_i),
    .dsp_ARREADY_o (dsp_ARREADY_o),
    .s_ARID_o      (s_ARID_o),
    .s_ARADDR_o    (s_ARADDR_o),
    .s_ARBURST_o   (s_ARBURST_o),
    .s_ARLEN_o     (s_ARLEN_o),
    .s_ARSIZE_o    (s_ARSIZE_o),
    .s_ARVALID_o   (s_ARVALID_o),
    .s_ARREADY_i   (s_ARREADY_i),
    .s_RLAST_i     (s_RLAST_i),
    .s_RVALID_i    (s_RVALID_i),
    .s_RREADY_i    (s_RREADY_i),
    .grant_mst_o   (grant_mst_o),
    .grant_push_o  (grant_push_o),
    .outst_full_o  (outst_full_o)
  );

  always #5 ACLK_i = ~ACLK_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge ACLK_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input int m);
    return (m == 1) ? 32'h4000_0010 : 32'h1000_0000;
  endfunction

  function automatic logic [2:0] len_of(input int m);
    return (m == 1) ? 3'd3 : 3'd1;
  endfunction

  function automatic logic [4:0] id_of(input int m);
    return (m == 1) ? 5'h11 : 5'h03;
  endfunction

  function automatic int pick(input logic [1:0] v);
`ifdef SA_AR_FIXED_PRIO_EN
    return v[0] ? 0 : 1;
`else
    if (exp_ptr == 0) return v[0] ? 0 : 1;
    return v[1] ? 1 : 0;
`endif
  endfunction

  // Requests with vld, holds s_ARREADY_i low for hold cycles, then handshakes.
  task automatic issue(input logic [1:0] vld, input bit with_rlast, input int hold);
    int exp_m;
    bit seen;
    exp_m = pick(vld);
    dsp_ARVALID_i = vld;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = s_ARVALID_o;
    end
    chk("ar_timeout", 64'(seen), 64'(1));
    if (seen) begin
      exp_ptr = (exp_m + 1) % 2;
      chk("dsp_ready", 64'(dsp_ARREADY_o), 64'(2'b01 << exp_m));
      chk("ar_addr", 64'(s_ARADDR_o), 64'(addr_of(exp_m)));
      chk("ar_len", 64'(s_ARLEN_o), 64'(len_of(exp_m)));
      chk("ar_id", 64'(s_ARID_o), 64'(id_of(exp_m)));
      for (int h = 0; h < hold; h++) begin
        tick();
        chk("bp_valid", 64'(s_ARVALID_o), 64'(1));
        chk("bp_addr", 64'(s_ARADDR_o), 64'(addr_of(exp_m)));
        chk("bp_ready", 64'(dsp_ARREADY_o), 64'(0));
      end
      s_ARREADY_i = 1'b1;
      if (with_rlast) begin
        s_RVALID_i = 1'b1; s_RREADY_i = 1'b1; s_RLAST_i = 1'b1;
      end
      #1;
      chk("push", 64'(grant_push_o), 64'(1));
      chk("gnt_mst", 64'(grant_mst_o), 64'(exp_m));
      tick();
      s_ARREADY_i = 1'b0;
      s_RVALID_i = 1'b0; s_RREADY_i = 1'b0; s_RLAST_i = 1'b0;
      if (!(with_rlast && exp_cnt > 0)) exp_cnt++;
      chk("push_clear", 64'(grant_push_o), 64'(0));
    end
  endtask

  task automatic rdrain(input int n);
    dsp_ARVALID_i = 2'b00;
    for (int i = 0; i < n; i++) begin
      s_RVALID_i = 1'b1; s_RREADY_i = 1'b1; s_RLAST_i = 1'b1;
      tick();
      if (exp_cnt > 0) exp_cnt--;
    end
    s_RVALID_i = 1'b0; s_RREADY_i = 1'b0; s_RLAST_i = 1'b0;
  endtask

  initial begin
    ARESETn_i     = 1'b0;
    dsp_ARID_i    = {id_of(1), id_of(0)};
    dsp_ARADDR_i  = {addr_of(1), addr_of(0)};
    dsp_ARBURST_i = {2'd1, 2'd1};
    dsp_ARLEN_i   = {len_of(1), len_of(0)};
    dsp_ARSIZE_i  = {3'd2, 3'd2};
    dsp_ARVALID_i = 2'b00;
    s_ARREADY_i   = 1'b0;
    s_RLAST_i     = 1'b0;
    s_RVALID_i    = 1'b0;
    s_RREADY_i    = 1'b0;
    tick();
    tick();
    chk("rst_valid", 64'(s_ARVALID_o), 64'(0));
    chk("rst_ready", 64'(dsp_ARREADY_o), 64'(0));
    chk("rst_push", 64'(grant_push_o), 64'(0));
    chk("rst_mst", 64'(grant_mst_o), 64'(0));
    chk("rst_addr", 64'(s_ARADDR_o), 64'(0));
    chk("rst_full", 64'(outst_full_o), 64'(0));
    chk("rst_cnt", 64'(dut.outst_cnt), 64'(0));
    ARESETn_i = 1'b1;

    // single request from master 1
    issue(2'b10, 1'b0, 0);
    dsp_ARVALID_i = 2'b00;
    chk("single_cnt", 64'(dut.outst_cnt), 64'(1));

    // continuous requests from both masters
    for (int i = 0; i < 4; i++) issue(2'b11, 1'b0, 0);

    // slave backpressure for 5 cycles
    issue(2'b11, 1'b0, 5);

    issue(2'b11, 1'b0, 0);
    chk("cnt7_full", 64'(outst_full_o), 64'(0));
    issue(2'b11, 1'b0, 0);
    chk("cnt8_full", 64'(outst_full_o), 64'(1));
    chk("cnt8", 64'(dut.outst_cnt), 64'(8));

    // limit reached: requests pending but nothing granted
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("full_noval", 64'(s_ARVALID_o), 64'(0));
      chk("full_nordy", 64'(dsp_ARREADY_o), 64'(0));
    end
    s_RVALID_i = 1'b1; s_RREADY_i = 1'b1; s_RLAST_i = 1'b1;
    tick();
    s_RVALID_i = 1'b0; s_RREADY_i = 1'b0; s_RLAST_i = 1'b0;
    exp_cnt--;
    chk("free_cnt", 64'(dut.outst_cnt), 64'(7));
    chk("free_full", 64'(outst_full_o), 64'(0));
    issue(2'b11, 1'b0, 0);
    chk("refill_cnt", 64'(dut.outst_cnt), 64'(exp_cnt));

    // simultaneous handshake and retirement at count 5
    rdrain(3);
    chk("cnt5", 64'(dut.outst_cnt), 64'(5));
    issue(2'b01, 1'b1, 0);
    dsp_ARVALID_i = 2'b00;
    chk("simul_cnt", 64'(dut.outst_cnt), 64'(5));

    // retirement at zero is ignored
    rdrain(7);
    chk("floor_cnt", 64'(dut.outst_cnt), 64'(0));

    // reset while an AR is pending
    issue(2'b10, 1'b0, 0);
    dsp_ARVALID_i = 2'b01;
    tick();
    chk("pre_rst_valid", 64'(s_ARVALID_o), 64'(1));
    exp_ptr = 1;
    ARESETn_i = 1'b0;
    dsp_ARVALID_i = 2'b00;
    tick();
    chk("mid_rst_valid", 64'(s_ARVALID_o), 64'(0));
    chk("mid_rst_cnt", 64'(dut.outst_cnt), 64'(0));
    exp_cnt = 0;
    exp_ptr = 0;
    ARESETn_i = 1'b1;
    issue(2'b11, 1'b0, 0);
    dsp_ARVALID_i = 2'b00;
    chk("post_rst_cnt", 64'(dut.outst_cnt), 64'(exp_cnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
